// File: rtl/vga_framebuffer_scanout_if.sv
// Renderer pixel-plot stream into the scanout block, plus the VGA pins it drives toward the DAC.
// The plot side has no handshake: the renderer issues one pixel per clock whenever it likes.
interface vga_framebuffer_scanout_if;
  logic       plot;
  logic [8:0] x_in;
  logic [8:0] y_in;
  logic [2:0] colour_in;
  logic [7:0] vga_r;
  logic [7:0] vga_g;
  logic [7:0] vga_b;
  logic       vga_hs;
  logic       vga_vs;
  logic       vga_blank_n;
  logic       vga_clk;
  logic       frame_start;

  modport master (
    output plot, x_in, y_in, colour_in,
    input  vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, vga_clk, frame_start
  );

  modport slave (
    input  plot, x_in, y_in, colour_in,
    output vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, vga_clk, frame_start
  );
endinterface

// File: rtl/vga_framebuffer_scanout.sv
// 320x240x3 frame buffer written by plot strobes and scanned out pixel-doubled as VGA.
// Counters to pins take 2 pixel ticks; no backpressure, a plot is accepted every clock.
module vga_framebuffer_scanout #(
  parameter int CLK_DIV   = 2,
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input logic                      clock,
  input logic                      reset,
  vga_framebuffer_scanout_if.slave bus
);
  localparam int FB_W     = 320;
  localparam int FB_H     = 240;
  localparam int FB_DEPTH = FB_W * FB_H;
  localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST   = 10'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);
  localparam logic [8:0] X_LIMIT  = 9'(FB_W);
  localparam logic [8:0] Y_LIMIT  = 9'(FB_H);

  logic [DIV_W-1:0] div;
  logic [9:0]       h_cnt;
  logic [9:0]       v_cnt;
  logic             pix_en;

  assign pix_en      = (div == DIV_LAST);
  assign bus.vga_clk = pix_en;

  always_ff @(posedge clock) begin
    if (reset) begin
      div   <= '0;
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      div <= '0;
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end else begin
      div <= div + 1'b1;
    end
  end

  logic blank_raw;
  logic hs_raw;
  logic vs_raw;

  assign blank_raw = (h_cnt >= H_VIS) || (v_cnt >= V_VIS);
  assign hs_raw    = !((h_cnt >= HS_START) && (h_cnt < HS_END));
  assign vs_raw    = !((v_cnt >= VS_START) && (v_cnt < VS_END));

  // row*320 built as row*256 + row*64; blanking addresses may run past the buffer and are masked.
  logic [16:0] rd_addr_nxt;
  logic [16:0] wr_addr;
  logic        wr_en;

  assign rd_addr_nxt = {v_cnt[9:1], 8'd0} + {2'd0, v_cnt[9:1], 6'd0} + {8'd0, h_cnt[9:1]};
  assign wr_addr     = {bus.y_in, 8'd0} + {2'd0, bus.y_in, 6'd0} + {8'd0, bus.x_in};
  assign wr_en       = bus.plot && (bus.x_in < X_LIMIT) && (bus.y_in < Y_LIMIT);

  logic [2:0] mem [0:FB_DEPTH-1];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= bus.colour_in;
    end
  end

  logic [16:0] rd_addr;
  logic        hs_s1;
  logic        vs_s1;
  logic        blank_s1;

  // Stage 1 registers address and raw timing; stage 2 reads the RAM (old data on a same-edge write).
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_addr         <= '0;
      hs_s1           <= 1'b1;
      vs_s1           <= 1'b1;
      blank_s1        <= 1'b1;
      bus.vga_r       <= '0;
      bus.vga_g       <= '0;
      bus.vga_b       <= '0;
      bus.vga_hs      <= 1'b1;
      bus.vga_vs      <= 1'b1;
      bus.vga_blank_n <= 1'b0;
      bus.frame_start <= 1'b0;
    end else begin
      bus.frame_start <= pix_en && (h_cnt == H_LAST) && (v_cnt == V_VIS - 10'd1);
      if (pix_en) begin
        rd_addr         <= rd_addr_nxt;
        hs_s1           <= hs_raw;
        vs_s1           <= vs_raw;
        blank_s1        <= blank_raw;
        bus.vga_r       <= {8{mem[rd_addr][2] & ~blank_s1}};
        bus.vga_g       <= {8{mem[rd_addr][1] & ~blank_s1}};
        bus.vga_b       <= {8{mem[rd_addr][0] & ~blank_s1}};
        bus.vga_hs      <= hs_s1;
        bus.vga_vs      <= vs_s1;
        bus.vga_blank_n <= ~blank_s1;
      end
    end
  end
endmodule
